// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 4-bit ALU core between two requesters.
// Define ALU_ARB_RR_EN for round-robin tie-break; default is fixed priority (req0).
module alu_arbiter #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [3:0]           op0,
    input  logic [3:0]           a0,
    input  logic [3:0]           b0,
    input  logic [3:0]           op1,
    input  logic [3:0]           a1,
    input  logic [3:0]           b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [3:0]           alu_op,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    input  logic [3:0]           alu_result,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [3:0]           rsp_result,
    output logic                 rsp_ovf,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic [1:0]           r_state;
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_id;
    logic                 r_err;
    logic [3:0]           r_op;
    logic [3:0]           r_a;
    logic [3:0]           r_b;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [3:0]           r_rsp_result;
    logic                 r_rsp_ovf;
    logic                 r_rsp_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic       w_any;
    logic       w_win;
    logic       w_grant;
    logic       w_err;
    logic [3:0] w_op;
    logic [3:0] w_a;
    logic [3:0] w_b;

    assign w_any   = req0 | req1;
    assign w_grant = w_any && (r_state != ST_EXEC);

`ifdef ALU_ARB_RR_EN
    logic r_last;

    // On a tie the requester not served last wins.
    assign w_win = (req0 & req1) ? ~r_last : req1;

    // Remember who was granted most recently; reset favours requester 0.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`else
    // Requester 0 always wins a tie.
    assign w_win = ~req0;
`endif

    assign w_op  = w_win ? op1 : op0;
    assign w_a   = w_win ? a1  : a0;
    assign w_b   = w_win ? b1  : b0;
    assign w_err = (w_op >= 4'hD) || ((w_op == 4'h9) && (w_b == 4'h0));

    // Control FSM: grant from IDLE/RESP, one EXEC cycle, then RESP.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (w_grant) begin
            r_state <= ST_EXEC;
        end else if (r_state == ST_EXEC) begin
            r_state <= ST_RESP;
        end else begin
            r_state <= ST_IDLE;
        end
    end

    // Latch the winner's operation and pulse its grant.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_id   <= 1'b0;
            r_err  <= 1'b0;
            r_op   <= 4'h0;
            r_a    <= 4'h0;
            r_b    <= 4'h0;
        end else begin
            r_gnt0 <= w_grant & ~w_win;
            r_gnt1 <= w_grant & w_win;
            if (w_grant) begin
                r_id  <= w_win;
                r_err <= w_err;
                r_op  <= w_op;
                r_a   <= w_a;
                r_b   <= w_b;
            end
        end
    end

    // Capture the settled core output at the end of EXEC; rejected ops read as zero.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 4'h0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= (r_state == ST_EXEC);
            if (r_state == ST_EXEC) begin
                r_rsp_id     <= r_id;
                r_rsp_result <= r_err ? 4'h0 : alu_result;
                r_rsp_ovf    <= r_err ? 1'b0 : alu_overflow;
                r_rsp_err    <= r_err;
            end
        end
    end

    // Count rejected responses, holding at all-ones.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if ((r_state == ST_EXEC) && r_err && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_ONE;
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign alu_op     = r_op;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state == ST_EXEC);
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed bench for alu_arbiter
// against a transaction-level reference model with a golden ALU core.
module tb_alu_arbiter;

    logic       clock;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] op0, a0, b0, op1, a1, b1;
    logic       gnt0, gnt1;
    logic [3:0] alu_op, alu_a, alu_b;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic       rsp_valid, rsp_id, rsp_ovf, rsp_err, busy;
    logic [3:0] rsp_result;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // expected outputs for the current cycle
    logic       e_gnt0, e_gnt1, e_busy, e_rv, e_id, e_ovf, e_err;
    logic [3:0] e_res, e_op, e_a, e_b;
    logic [7:0] e_cnt;
    // operation in flight and arbitration history
    logic       m_id, m_err, m_last;
    logic [4:0] m_gold;

    logic [30:0] obs, exp;

    alu_arbiter #(.ERR_CNT_W(8)) dut (
        .clock(clock), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .op0(op0), .a0(a0), .b0(b0),
        .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .busy(busy), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // golden ALU core: returns {overflow, result}
    function automatic logic [4:0] golden(input logic [3:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        logic [4:0] r;
        logic [7:0] p;
        r = 5'd0;
        p = 8'd0;
        case (op)
            4'h0: r = {1'b0, a & b};
            4'h1: r = {1'b0, a | b};
            4'h2: r = {1'b0, a ^ b};
            4'h3: begin
                r[3:0] = a + b;
                r[4]   = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'h4: begin
                r[3:0] = a - b;
                r[4]   = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'h5: r = {1'b0, ~a};
            4'h6: r = {a[3], a[2:0], 1'b0};
            4'h7: r = {2'b00, a[3:1]};
            4'h8: begin
                p = {4'h0, a} * {4'h0, b};
                r = {|p[7:4], p[3:0]};
            end
            4'h9: r = {1'b0, (b == 4'h0) ? 4'h0 : a % b};
            4'hA: r = {a == 4'h7, a + 4'h1};
            4'hB: r = {a == 4'h8, a - 4'h1};
            4'hC: r = {1'b0, b};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        {alu_overflow, alu_result} = golden(alu_op, alu_a, alu_b);
    end

    assign obs = {gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_result,
                  rsp_ovf, rsp_err, alu_op, alu_a, alu_b, err_count};
    assign exp = {e_gnt0, e_gnt1, e_busy, e_rv, e_id, e_res,
                  e_ovf, e_err, e_op, e_a, e_b, e_cnt};

    task automatic model_reset();
        e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_rv = 0; e_id = 0;
        e_res = 0; e_ovf = 0; e_err = 0;
        e_op = 0; e_a = 0; e_b = 0; e_cnt = 0;
        m_id = 0; m_err = 0; m_gold = 0; m_last = 1;
    endtask

    // advance one clock and update the expected view for the new cycle
    task automatic step();
        logic w;
        if (e_busy) begin
            e_rv  = 1'b1;
            e_id  = m_id;
            e_err = m_err;
            e_res = m_err ? 4'h0 : m_gold[3:0];
            e_ovf = m_err ? 1'b0 : m_gold[4];
            if (m_err && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
        end else begin
            e_rv = 1'b0;
        end
        if (!e_busy && (req0 || req1)) begin
`ifdef ALU_ARB_RR_EN
            if (req0 && !req1)      w = 1'b0;
            else if (req1 && !req0) w = 1'b1;
            else                    w = (m_last == 1'b0);
`else
            w = req0 ? 1'b0 : 1'b1;
`endif
            e_gnt0 = (w == 1'b0);
            e_gnt1 = (w == 1'b1);
            e_busy = 1'b1;
            m_id   = w;
            m_last = w;
            e_op   = w ? op1 : op0;
            e_a    = w ? a1  : a0;
            e_b    = w ? b1  : b0;
            m_err  = (e_op >= 4'hD) || (e_op == 4'h9 && e_b == 4'h0);
            m_gold = golden(e_op, e_a, e_b);
        end else begin
            e_gnt0 = 1'b0;
            e_gnt1 = 1'b0;
            e_busy = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic new_op(input logic r);
        if (r) begin
            op1 = 4'($urandom_range(0, 15));
            a1 = 4'($urandom); b1 = 4'($urandom);
        end else begin
            op0 = 4'($urandom_range(0, 15));
            a0 = 4'($urandom); b0 = 4'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        op0 = 0; a0 = 0; b0 = 0; op1 = 0; a1 = 0; b1 = 0;
        model_reset();
        repeat (2) @(negedge clock);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs, exp);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp);
        end
    endtask

    task automatic test_single();
        req0 = 1; op0 = 4'h3; a0 = 4'd5; b0 = 4'd6;
        step();
        n_tests++;
        if (obs !== exp || gnt0 !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gnt cyc=%0d got=%h exp=%h", cyc, obs, exp);
        end
        req0 = 0;
        step();
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err} !== 8'b1_0_1011_1_0) begin
            n_fail++;
            $display("FAIL single_rsp got v=%b id=%b res=%h ovf=%b err=%b exp 1 0 b 1 0",
                     rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err);
        end
        step();
        n_tests++;
        if (obs !== exp || rsp_valid !== 1'b0 || rsp_result !== 4'hB) begin
            n_fail++;
            $display("FAIL single_hold cyc=%0d got=%h exp=%h", cyc, obs, exp);
        end
    endtask

    task automatic test_errors();
        req1 = 1; op1 = 4'hE; a1 = 4'd3; b1 = 4'd2;
        step();
        req1 = 0;
        step();
        n_tests++;
        if (obs !== exp || {rsp_valid, rsp_id, rsp_err, rsp_result, err_count} !==
                           {1'b1, 1'b1, 1'b1, 4'h0, 8'd1}) begin
            n_fail++;
            $display("FAIL err_undef got=%h exp=%h cnt=%0d", obs, exp, err_count);
        end
        step();
        req0 = 1; op0 = 4'h9; a0 = 4'd7; b0 = 4'd0;
        step();
        req0 = 0;
        step();
        n_tests++;
        if (obs !== exp || {rsp_err, rsp_result, rsp_ovf, err_count} !==
                           {1'b1, 4'h0, 1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL err_mod0 got=%h exp=%h cnt=%0d", obs, exp, err_count);
        end
        step();
    endtask

    // both requesters held high; RR alternates, fixed priority serves only req0
    task automatic test_tie();
        int g0 = 0;
        int g1 = 0;
        req0 = 1; req1 = 1;
        new_op(0); new_op(1);
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL tie cyc=%0d got=%h exp=%h", cyc, obs, exp);
            end
            if (gnt0) g0++;
            if (gnt1) g1++;
            if (e_gnt0) new_op(0);
            if (e_gnt1) new_op(1);
        end
        req0 = 0; req1 = 0;
        step(); step();
        n_tests++;
`ifdef ALU_ARB_RR_EN
        if (g0 != 2 || g1 != 2) begin
`else
        if (g0 != 4 || g1 != 0) begin
`endif
            n_fail++;
            $display("FAIL tie_counts got g0=%0d g1=%0d", g0, g1);
        end
    endtask

    task automatic test_back_to_back();
        req0 = 1; new_op(0);
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (obs !== exp || busy !== ((i % 2) == 0) || gnt0 !== ((i % 2) == 0)
                || rsp_valid !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL b2b i=%0d got=%h exp=%h", i, obs, exp);
            end
            if (e_gnt0) new_op(0);
        end
        req0 = 0;
        step(); step();
    endtask

    task automatic test_saturate();
        int bad = 0;
        req0 = 1; op0 = 4'hF; a0 = 4'd1; b0 = 4'd1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (obs !== exp) bad++;
        end
        req0 = 0;
        step(); step();
        n_tests++;
        if (bad != 0 || err_count !== 8'hFF || obs !== exp) begin
            n_fail++;
            $display("FAIL saturate got cnt=%h bad_cycles=%0d exp cnt=ff", err_count, bad);
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1; req1 = 0; op0 = 4'h3; a0 = 4'($urandom); b0 = 4'($urandom);
        step();
        req0 = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs !== exp || obs !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%h exp=%h", obs, exp);
        end
        @(negedge clock);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs !== exp || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet i=%0d got=%h exp=%h", i, obs, exp);
            end
        end
        req0 = 1; req1 = 1; new_op(0); new_op(1);
        step();
        n_tests++;
        if (obs !== exp || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tie got=%h exp=%h", obs, exp);
        end
        req0 = 0; req1 = 0;
        step(); step();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp);
            end
            if (e_gnt0) begin
                if ($urandom_range(0, 1) == 0) req0 = 0; else new_op(0);
            end else if (req0) begin
                if ($urandom_range(0, 3) == 0) begin a0 = 4'($urandom); b0 = 4'($urandom); end
            end else if ($urandom_range(0, 9) < 3) begin
                req0 = 1; new_op(0);
            end
            if (e_gnt1) begin
                if ($urandom_range(0, 1) == 0) req1 = 0; else new_op(1);
            end else if (req1) begin
                if ($urandom_range(0, 3) == 0) begin a1 = 4'($urandom); b1 = 4'($urandom); end
            end else if ($urandom_range(0, 9) < 3) begin
                req1 = 1; new_op(1);
            end
        end
        req0 = 0; req1 = 0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_errors();
        test_tie();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 4-bit ALU core between two requesters, such as the switch-input front end and a scripted test sequencer. The block sits between the requesters and the ALU core, which uses the team's opcode map 0x0–0xC. It arbitrates requests, latches the operands, and drives the ALU from registers. It then captures the result and overflow and returns them with the requester ID and an error flag. The registered outputs feed the seven-segment display mux.

## Interface
Parameters:
- ERR_CNT_W, default 8: width of the saturating error counter.

Ports:
- clock, input, 1: system clock; everything is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req0 / req1, input, 1: request from requester 0 / 1; held high until granted.
- op0 / op1, input, 4: opcode; stable while req is high.
- a0, b0 / a1, b1, input, 4 each: operands; stable while req is high.
- gnt0 / gnt1, output, 1: one-cycle pulse; the operands were latched at the preceding edge.
- alu_op, output, 4: registered opcode to the ALU core.
- alu_a, alu_b, output, 4 each: registered operands to the ALU core.
- alu_result, input, 4: ALU core result (combinational from alu_*).
- alu_overflow, input, 1: ALU core overflow flag.
- rsp_valid, output, 1: one-cycle pulse; the rsp_* outputs are valid.
- rsp_id, output, 1: requester served.
- rsp_result, output, 4: captured result.
- rsp_ovf, output, 1: captured overflow.
- rsp_err, output, 1: the operation was rejected.
- busy, output, 1: high in EXEC.
- err_count, output, ERR_CNT_W: count of rsp_err responses; saturates at all-ones.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE or RESP → EXEC when req0 | req1 at the edge:
  - latch the winner's op/a/b into alu_op/alu_a/alu_b;
  - set the grant pointer and pulse gnt of the winner;
  - latch a per-op error flag.
- IDLE → IDLE when there is no request.
- EXEC → RESP, unconditionally:
  - capture alu_result and alu_overflow into rsp_result and rsp_ovf;
  - set rsp_valid=1 and rsp_id=winner.
- RESP → IDLE when there is no request; otherwise RESP → EXEC with a new grant.
- Arbitration when both requests are high: the requester not granted last wins (round-robin).
  - After reset the pointer is "last=1", so requester 0 wins the first tie.
- Error conditions:
  - op ≥ 0xD (undefined opcode);
  - op = 0x9 (A mod B) with B = 0.
- Behaviour on error:
  - the grant and EXEC happen normally;
  - rsp_result=0, rsp_ovf=0, rsp_err=1;
  - err_count increments and saturates;
  - alu_op is still driven, and the core's output is ignored.
- rsp_* outputs hold their value after rsp_valid drops; only rsp_valid pulses.
- A requester that sees gnt must drop req, or present a new op, before the next sampling edge (the RESP edge).
  - If req is still high at that edge, it is a new request.
- Operand changes while req is high and no gnt has been seen are legal; the values at the granting edge are used.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE;
  - gnt0=gnt1=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovf=0, rsp_err=0;
  - alu_op/alu_a/alu_b=0, busy=0, err_count=0, pointer="last=1".
- Reset mid-operation discards the in-flight operation and produces no response.
- Latency:
  - req sampled at edge k;
  - gnt and busy are high in cycle k→k+1;
  - rsp_valid is high in cycle k+1→k+2.
- Throughput: one operation every 2 cycles under continuous requests.
- Alternating service: both requests held high give grants 0,1,0,1…; rsp_id follows the same order.
- The ALU core has one full cycle (EXEC) to settle; the combinational path is alu_* regs → core → rsp regs.
- Simultaneous events:
  - a grant at the RESP edge co-occurs with the rsp_valid falling edge;
  - the new gnt and the old response never overlap in the same cycle.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration as above.
- ALU_ARB_RR_EN undefined: fixed priority, where requester 0 always wins ties.
  - The pointer register is removed.
  - Requester 1 may starve; this is acceptable for single-requester builds.

## Test plan
- Single requester: req0, op=0x3, a0=5, b0=6 at edge 0 → gnt0 pulse in cycle 0–1; rsp_valid in cycle 1–2 with rsp_id=0, rsp_result=0xB, rsp_ovf=1, rsp_err=0.
- Tie, round-robin: req0/req1 held 8 cycles with different ops → grants 0,1,0,1; each rsp_id and rsp_result matches the corresponding request's golden ALU model.
- Errors:
  - op1=0xE → rsp_err=1, rsp_result=0, err_count=1;
  - op0=0x9, b0=0 → rsp_err=1, err_count=2.
  - Force 300 errors → err_count holds at 0xFF.
- Reset mid-op: assert rst_n low during EXEC → all outputs 0 immediately; no rsp_valid after release; the next tie grants requester 0.
- Back-to-back: req0 held continuously → gnt0 every 2 cycles, rsp_valid every 2 cycles, busy toggling 1,0.
- Fixed priority (ALU_ARB_RR_EN undefined): both requests held 6 cycles → only gnt0 pulses; gnt1 stays 0.
